// File: rtl/xif_apu_bridge_if.sv
// Bundle of the XIF issue/commit/result channels and the APU request/response port
// seen by xif_apu_bridge. The bridge connects through the slave modport.
interface xif_apu_bridge_if #(
  parameter int unsigned ID_WIDTH = 4
);
  logic                issue_valid;
  logic                issue_ready;
  logic [31:0]         issue_instr;
  logic [ID_WIDTH-1:0] issue_id;
  logic [31:0]         issue_rs0;
  logic [31:0]         issue_rs1;
  logic [1:0]          issue_rs_valid;
  logic                issue_accept;
  logic                issue_writeback;

  logic                commit_valid;
  logic [ID_WIDTH-1:0] commit_id;
  logic                commit_kill;

  logic                apu_req;
  logic                apu_gnt;
  logic [95:0]         apu_operands_o;
  logic [5:0]          apu_op;
  logic [14:0]         apu_flags_o;
  logic                apu_rvalid;
  logic [31:0]         apu_result;

  logic                result_valid;
  logic                result_ready;
  logic [ID_WIDTH-1:0] result_id;
  logic [31:0]         result_data;
  logic [4:0]          result_rd;
  logic                result_we;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    output commit_valid, commit_id, commit_kill,
    output apu_gnt, apu_rvalid, apu_result,
    output result_ready,
    input  issue_ready, issue_accept, issue_writeback,
    input  apu_req, apu_operands_o, apu_op, apu_flags_o,
    input  result_valid, result_id, result_data, result_rd, result_we
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    input  commit_valid, commit_id, commit_kill,
    input  apu_gnt, apu_rvalid, apu_result,
    input  result_ready,
    output issue_ready, issue_accept, issue_writeback,
    output apu_req, apu_operands_o, apu_op, apu_flags_o,
    output result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/xif_apu_bridge.sv
// XIF-to-APU bridge: holds one offloaded OP-V instruction until commit, replays it as an
// APU request and returns the APU result on the XIF result channel.
module xif_apu_bridge #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter logic [6:0]  OPCODE_OPV = 7'h57
) (
  input  logic           clk,
  input  logic           reset,
  xif_apu_bridge_if.slave bus,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitCommit,
    StReq,
    StWaitResp,
    StResult
  } state_e;

  state_e state_q, state_d;

  logic [31:0]         instr_q;
  logic [31:0]         rs0_q;
  logic [31:0]         rs1_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                wb_q;
  logic [31:0]         data_q;

  // Issue-side decode
  logic [2:0] issue_funct3;
  logic [5:0] issue_funct6;
  logic       dec_accept;
  logic       dec_writeback;
  logic       ready_int;
  logic       issue_hs;
  logic       accept_hs;
  logic       issue_commit;
  logic       stored_commit;
  logic       capture_result;

  assign issue_funct3  = bus.issue_instr[14:12];
  assign issue_funct6  = bus.issue_instr[31:26];
  assign dec_accept    = (bus.issue_instr[6:0] == OPCODE_OPV);
  assign dec_writeback = dec_accept &&
                         ((issue_funct3 == 3'b111) ||
                          ((issue_funct3 == 3'b010) && (issue_funct6 == 6'b010000)));

  // Reset gates ready so the issue channel reads all-zero while reset is held.
  assign ready_int = !reset && (state_q == StIdle) &&
                     (!dec_accept || (bus.issue_rs_valid == 2'b11));
  assign issue_hs  = bus.issue_valid && ready_int;
  assign accept_hs = issue_hs && dec_accept;

  assign issue_commit  = bus.commit_valid && (bus.commit_id == bus.issue_id);
  assign stored_commit = bus.commit_valid && (bus.commit_id == id_q);

  assign capture_result = ((state_q == StReq) && bus.apu_gnt && bus.apu_rvalid) ||
                          ((state_q == StWaitResp) && bus.apu_rvalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept_hs) begin
          if (issue_commit) begin
            state_d = bus.commit_kill ? StIdle : StReq;
          end else begin
            state_d = StWaitCommit;
          end
        end
      end
      StWaitCommit: begin
        if (stored_commit) begin
          state_d = bus.commit_kill ? StIdle : StReq;
        end
      end
      StReq: begin
        if (bus.apu_gnt) begin
          state_d = bus.apu_rvalid ? StResult : StWaitResp;
        end
      end
      StWaitResp: begin
        if (bus.apu_rvalid) begin
          state_d = StResult;
        end
      end
      StResult: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      rs0_q   <= '0;
      rs1_q   <= '0;
      id_q    <= '0;
      wb_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept_hs) begin
        instr_q <= bus.issue_instr;
        rs0_q   <= bus.issue_rs0;
        rs1_q   <= bus.issue_rs1;
        id_q    <= bus.issue_id;
        wb_q    <= dec_writeback;
      end
      if (capture_result) begin
        data_q <= bus.apu_result;
      end
    end
  end

  always_comb begin
    bus.issue_ready     = ready_int;
    bus.issue_accept    = accept_hs;
    bus.issue_writeback = issue_hs && dec_writeback;
    bus.apu_req         = 1'b0;
    bus.apu_operands_o  = '0;
    bus.apu_op          = '0;
    bus.apu_flags_o     = '0;
    bus.result_valid    = 1'b0;
    bus.result_id       = '0;
    bus.result_data     = '0;
    bus.result_rd       = '0;
    bus.result_we       = 1'b0;
    busy_o              = (state_q != StIdle);
    case (state_q)
      StReq: begin
        bus.apu_req        = 1'b1;
        bus.apu_operands_o = {instr_q, rs1_q, rs0_q};
        bus.apu_op         = instr_q[31:26];
        bus.apu_flags_o    = {instr_q[14:12], instr_q[11:7], instr_q[6:0]};
      end
      StResult: begin
        bus.result_valid = 1'b1;
        bus.result_id    = id_q;
        bus.result_data  = data_q;
        bus.result_rd    = instr_q[11:7];
        bus.result_we    = wb_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xif_apu_bridge.sv
// Bench for xif_apu_bridge: directed scenarios with literal expectations, then random
// traffic checked every cycle against a flag-based transaction model.
module tb_xif_apu_bridge;

  localparam int unsigned IdW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  xif_apu_bridge_if #(.ID_WIDTH(IdW)) bus_if ();

  xif_apu_bridge #(.ID_WIDTH(IdW), .OPCODE_OPV(7'h57)) dut (
    .clk    (clk),
    .reset  (rst),
    .bus    (bus_if),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one transaction, described by what has happened to it so far.
  logic           m_valid = 1'b0;
  logic           m_committed = 1'b0;
  logic           m_granted = 1'b0;
  logic           m_done = 1'b0;
  logic [31:0]    m_instr = '0;
  logic [31:0]    m_rs0 = '0;
  logic [31:0]    m_rs1 = '0;
  logic [IdW-1:0] m_id = '0;
  logic           m_wb = 1'b0;
  logic [31:0]    m_data = '0;

  function automatic logic is_opv(input logic [31:0] i);
    return i[6:0] == 7'h57;
  endfunction

  function automatic logic is_wb(input logic [31:0] i);
    return is_opv(i) && (i[14:12] == 3'd7 || (i[14:12] == 3'd2 && i[31:26] == 6'h10));
  endfunction

  function automatic logic model_ready();
    return !rst && !m_valid && (!is_opv(bus_if.issue_instr) || bus_if.issue_rs_valid == 2'b11);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_committed = 0; m_granted = 0; m_done = 0;
      m_instr = 0; m_rs0 = 0; m_rs1 = 0; m_id = 0; m_wb = 0; m_data = 0;
    end else if (!m_valid) begin
      if (bus_if.issue_valid && model_ready() && is_opv(bus_if.issue_instr)) begin
        m_valid = 1; m_committed = 0; m_granted = 0; m_done = 0;
        m_instr = bus_if.issue_instr; m_rs0 = bus_if.issue_rs0; m_rs1 = bus_if.issue_rs1;
        m_id = bus_if.issue_id; m_wb = is_wb(bus_if.issue_instr);
        if (bus_if.commit_valid && bus_if.commit_id == bus_if.issue_id) begin
          if (bus_if.commit_kill) m_valid = 0;
          else m_committed = 1;
        end
      end
    end else if (!m_committed) begin
      if (bus_if.commit_valid && bus_if.commit_id == m_id) begin
        if (bus_if.commit_kill) m_valid = 0;
        else m_committed = 1;
      end
    end else if (!m_granted) begin
      if (bus_if.apu_gnt) begin
        m_granted = 1;
        if (bus_if.apu_rvalid) begin m_done = 1; m_data = bus_if.apu_result; end
      end
    end else if (!m_done) begin
      if (bus_if.apu_rvalid) begin m_done = 1; m_data = bus_if.apu_result; end
    end else if (bus_if.result_ready) begin
      m_valid = 0; m_committed = 0; m_granted = 0; m_done = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic hs;
    logic req;
    hs  = bus_if.issue_valid && model_ready();
    req = m_committed && !m_granted;
    check("issue_ready", bus_if.issue_ready, model_ready());
    check("issue_accept", bus_if.issue_accept, hs && is_opv(bus_if.issue_instr));
    check("issue_writeback", bus_if.issue_writeback, hs && is_wb(bus_if.issue_instr));
    check("apu_req", bus_if.apu_req, req);
    check("apu_operands", bus_if.apu_operands_o, req ? {m_instr, m_rs1, m_rs0} : 96'h0);
    check("apu_op", bus_if.apu_op, req ? m_instr[31:26] : 6'h0);
    check("apu_flags", bus_if.apu_flags_o, req ? m_instr[14:0] : 15'h0);
    check("result_valid", bus_if.result_valid, m_done);
    check("result_id", bus_if.result_id, m_done ? m_id : '0);
    check("result_data", bus_if.result_data, m_done ? m_data : 32'h0);
    check("result_rd", bus_if.result_rd, m_done ? m_instr[11:7] : 5'h0);
    check("result_we", bus_if.result_we, m_done && m_wb);
    check("busy", busy, m_valid);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus_if.issue_valid = 0; bus_if.issue_instr = 0; bus_if.issue_id = 0;
    bus_if.issue_rs0 = 0; bus_if.issue_rs1 = 0; bus_if.issue_rs_valid = 0;
    bus_if.commit_valid = 0; bus_if.commit_id = 0; bus_if.commit_kill = 0;
    bus_if.apu_gnt = 0; bus_if.apu_rvalid = 0; bus_if.apu_result = 0;
    bus_if.result_ready = 0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [IdW-1:0] id,
                       input logic [31:0] rs0, input logic [31:0] rs1, input logic [1:0] rsv);
    bus_if.issue_valid = 1; bus_if.issue_instr = instr; bus_if.issue_id = id;
    bus_if.issue_rs0 = rs0; bus_if.issue_rs1 = rs1; bus_if.issue_rs_valid = rsv;
  endtask

  localparam logic [31:0] Vsetvli = 32'h0C70_7557;
  localparam logic [31:0] Vplain  = 32'h0200_0557;

  initial begin
    logic [31:0] r;
    quiet();
    mid();
    check("rst_ready", bus_if.issue_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(); rst = 0;
    mid();
    check("idle_ready", bus_if.issue_ready, 1'b1);

    // vsetvli with same-cycle commit, grant and response
    tick();
    issue(Vsetvli, 4'd3, 32'd17, 32'd0, 2'b11);
    bus_if.commit_valid = 1; bus_if.commit_id = 4'd3;
    bus_if.apu_gnt = 1; bus_if.apu_rvalid = 1; bus_if.apu_result = 32'd8;
    mid();
    check("t1_accept", bus_if.issue_accept, 1'b1);
    check("t1_wb", bus_if.issue_writeback, 1'b1);
    tick(); bus_if.issue_valid = 0; bus_if.commit_valid = 0;
    mid();
    check("t1_req", bus_if.apu_req, 1'b1);
    check("t1_rs0", bus_if.apu_operands_o[31:0], 32'd17);
    check("t1_op", bus_if.apu_op, 6'd3);
    check("t1_flags", bus_if.apu_flags_o, 15'h7557);
    tick(); bus_if.apu_gnt = 0; bus_if.apu_rvalid = 0;
    mid();
    check("t1_rvalid", bus_if.result_valid, 1'b1);
    check("t1_id", bus_if.result_id, 4'd3);
    check("t1_data", bus_if.result_data, 32'd8);
    check("t1_rd", bus_if.result_rd, 5'd10);
    check("t1_we", bus_if.result_we, 1'b1);
    tick(); bus_if.result_ready = 1;
    tick(); bus_if.result_ready = 0;
    mid();
    check("t1_done", bus_if.result_valid, 1'b0);
    check("t1_idle", busy, 1'b0);

    // non-OP-V instruction is rejected without operands
    tick(); issue(32'h0000_0013, 4'd1, 0, 0, 2'b00);
    mid();
    check("t2_ready", bus_if.issue_ready, 1'b1);
    check("t2_accept", bus_if.issue_accept, 1'b0);
    tick(); bus_if.issue_valid = 0;
    mid();
    check("t2_busy", busy, 1'b0);
    check("t2_req", bus_if.apu_req, 1'b0);

    // accepted then killed two cycles later
    tick(); issue(Vplain, 4'd5, 32'h55, 32'h66, 2'b11);
    mid();
    check("t3_accept", bus_if.issue_accept, 1'b1);
    check("t3_wb", bus_if.issue_writeback, 1'b0);
    tick(); bus_if.issue_valid = 0;
    mid(); check("t3_req_a", bus_if.apu_req, 1'b0);
    tick();
    mid(); check("t3_req_b", bus_if.apu_req, 1'b0);
    tick(); bus_if.commit_valid = 1; bus_if.commit_id = 4'd5; bus_if.commit_kill = 1;
    mid(); check("t3_req_c", bus_if.apu_req, 1'b0);
    tick(); bus_if.commit_valid = 0; bus_if.commit_kill = 0;
    mid();
    check("t3_busy", busy, 1'b0);
    check("t3_req_d", bus_if.apu_req, 1'b0);
    check("t3_noresult", bus_if.result_valid, 1'b0);

    // operands not ready for three cycles
    tick(); issue(Vplain, 4'd2, 32'h1111_2222, 32'h3333_4444, 2'b01);
    for (int i = 0; i < 3; i++) begin
      mid(); check("t4_notready", bus_if.issue_ready, 1'b0);
      tick();
    end
    bus_if.issue_rs_valid = 2'b11;
    mid();
    check("t4_ready", bus_if.issue_ready, 1'b1);
    check("t4_accept", bus_if.issue_accept, 1'b1);

    // foreign commit ignored, grant stalled, late response, result back-pressure
    tick(); bus_if.issue_valid = 0; bus_if.commit_valid = 1; bus_if.commit_id = 4'd7;
    mid(); check("t5_foreign", busy, 1'b1);
    tick(); bus_if.commit_id = 4'd2;
    mid(); check("t5_wait", bus_if.apu_req, 1'b0);
    tick(); bus_if.commit_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t5_req_held", bus_if.apu_req, 1'b1);
      check("t5_ops_held", bus_if.apu_operands_o, {Vplain, 32'h3333_4444, 32'h1111_2222});
      tick();
    end
    bus_if.apu_gnt = 1;
    tick(); bus_if.apu_gnt = 0;
    mid(); check("t5_req_drop", bus_if.apu_req, 1'b0);
    tick(); bus_if.apu_rvalid = 1; bus_if.apu_result = 32'hCAFE_F00D;
    mid(); check("t5_not_yet", bus_if.result_valid, 1'b0);
    tick(); bus_if.apu_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t5_rv_held", bus_if.result_valid, 1'b1);
      check("t5_data_held", bus_if.result_data, 32'hCAFE_F00D);
      check("t5_we", bus_if.result_we, 1'b0);
      tick();
    end
    bus_if.result_ready = 1;
    tick(); bus_if.result_ready = 0;
    mid(); check("t5_done", bus_if.result_valid, 1'b0);

    // reset while waiting for the response
    tick(); issue(Vplain, 4'd9, 32'h9, 32'h9, 2'b11);
    bus_if.commit_valid = 1; bus_if.commit_id = 4'd9; bus_if.apu_gnt = 1;
    tick(); bus_if.issue_valid = 0; bus_if.commit_valid = 0;
    tick(); bus_if.apu_gnt = 0;
    mid(); check("t6_waitresp", busy, 1'b1);
    @(posedge clk); #2 rst = 1;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_req", bus_if.apu_req, 1'b0);
    check("t6_rv", bus_if.result_valid, 1'b0);
    check("t6_ready", bus_if.issue_ready, 1'b0);
    tick(); rst = 0;
    tick(); issue(Vsetvli, 4'd4, 32'd1, 32'd2, 2'b11);
    mid(); check("t6_reissue", bus_if.issue_accept, 1'b1);
    tick(); quiet();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      r = $urandom();
      case ($urandom_range(0, 4))
        0: r = {r[31:15], 3'b111, r[11:7], 7'h57};
        1: r = {6'b010000, r[25:15], 3'b010, r[11:7], 7'h57};
        2: r = {r[31:7], 7'h57};
        3: ;
        default: r = 32'h0000_0013;
      endcase
      bus_if.issue_valid = 1'($urandom_range(0, 1));
      bus_if.issue_instr = r;
      bus_if.issue_id = IdW'($urandom());
      bus_if.issue_rs0 = $urandom();
      bus_if.issue_rs1 = $urandom();
      bus_if.issue_rs_valid = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom());
      bus_if.commit_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) bus_if.commit_id = m_valid ? m_id : bus_if.issue_id;
      else bus_if.commit_id = IdW'($urandom());
      bus_if.commit_kill = ($urandom_range(0, 3) == 0);
      bus_if.apu_gnt = 1'($urandom_range(0, 1));
      bus_if.apu_rvalid = 1'($urandom_range(0, 1));
      bus_if.apu_result = $urandom();
      bus_if.result_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
    end
    tick(); quiet(); rst = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
